// File: rtl/mms_pkg.sv
// Shared ITLB definitions: geometry, controller state encoding, PTE type and
// the lowest-index one-hot priority helper used by both hit and victim paths.
package mms_pkg;

    localparam int ITLB_ENTRY_SIZE = 31;
    localparam int VPN_W           = 27;
    localparam int MXLEN           = 64;
    localparam int VICTIM_PTR_W    = $clog2(ITLB_ENTRY_SIZE);

    typedef logic [MXLEN-1:0]           pte_t;
    typedef logic [ITLB_ENTRY_SIZE-1:0] entry_vec_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PTW_REQ  = 2'd1,
        PTW_WAIT = 2'd2,
        REFILL   = 2'd3
    } itlb_ctrl_state_e;

    // Isolates the lowest set bit (two's-complement trick); zero stays zero.
    function automatic entry_vec_t lowest_one(input entry_vec_t v);
        return v & (~v + entry_vec_t'(1));
    endfunction

endpackage

// File: rtl/itlb_victim_sel.sv
// Victim selection for ITLB refills: round-robin pointer, optionally preceded
// by an invalid-first priority encoder when ITLB_INVALID_FIRST_EN is defined.
module itlb_victim_sel
    import mms_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  entry_vec_t valid_i,
    input  logic       commit_i,
    output entry_vec_t victim_oh_o
);

    logic [VICTIM_PTR_W-1:0] ptr_q, ptr_d;
    entry_vec_t              ptr_oh;
    logic                    use_ptr;

    always_comb begin
        ptr_oh = entry_vec_t'(1) << ptr_q;
`ifdef ITLB_INVALID_FIRST_EN
        use_ptr     = &valid_i;
        victim_oh_o = use_ptr ? ptr_oh : lowest_one(~valid_i);
`else
        use_ptr     = 1'b1;
        victim_oh_o = ptr_oh;
`endif
        // The pointer only moves when it actually chose the committed victim.
        ptr_d = ptr_q;
        if (commit_i && use_ptr) begin
            ptr_d = (ptr_q == VICTIM_PTR_W'(ITLB_ENTRY_SIZE - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`ifndef ITLB_INVALID_FIRST_EN
    logic unused_valid;
    assign unused_valid = ^valid_i;
`endif

endmodule

// File: rtl/itlb_refill_ctrl.sv
// ITLB miss handling: hit qualification, PTW request/response, and victim refill.
// Optional ITLB_INVALID_FIRST_EN makes the victim the lowest invalid entry.
module itlb_refill_ctrl
    import mms_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       lookup_valid_i,
    input  logic [VPN_W-1:0]           lookup_vpn_i,
    input  logic [ITLB_ENTRY_SIZE-1:0] hit_vec_i,
    output logic                       lookup_ready_o,
    output logic [ITLB_ENTRY_SIZE-1:0] rd_en_o,
    output logic                       hit_o,
    output logic                       ptw_req_valid_o,
    input  logic                       ptw_req_ready_i,
    output logic [VPN_W-1:0]           ptw_req_vpn_o,
    input  logic                       ptw_resp_valid_i,
    input  logic [MXLEN-1:0]           ptw_resp_pte_i,
    input  logic                       ptw_resp_fault_i,
    output logic [ITLB_ENTRY_SIZE-1:0] wr_en_o,
    output logic [MXLEN-1:0]           pte_wr_o,
    output logic [VPN_W-1:0]           tag_wr_vpn_o,
    output logic [ITLB_ENTRY_SIZE-1:0] valid_o,
    output logic                       refill_done_o,
    output logic                       fault_o,
    input  logic                       flush_i
);

    itlb_ctrl_state_e state_q, state_d;
    entry_vec_t       valid_q, valid_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    pte_t             pte_q, pte_d;
    logic             discard_q, discard_d;

    entry_vec_t hit_qual;
    entry_vec_t victim_oh;
    logic       in_refill;

    assign hit_qual  = hit_vec_i & valid_q;
    assign in_refill = (state_q == REFILL);

    itlb_victim_sel u_victim_sel (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_q),
        .commit_i    (in_refill),
        .victim_oh_o (victim_oh)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= '0;
            vpn_q     <= '0;
            pte_q     <= '0;
            discard_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            vpn_q     <= vpn_d;
            pte_q     <= pte_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        vpn_d     = vpn_q;
        pte_d     = pte_q;
        discard_d = discard_q;
        case (state_q)
            IDLE: begin
                if (!flush_i && lookup_valid_i && !(|hit_qual)) begin
                    vpn_d   = lookup_vpn_i;
                    state_d = PTW_REQ;
                end
            end
            PTW_REQ: begin
                // A flush racing the handshake still has a walk in flight to drain.
                if (ptw_req_ready_i) begin
                    state_d   = PTW_WAIT;
                    discard_d = flush_i;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            PTW_WAIT: begin
                if (ptw_resp_valid_i) begin
                    discard_d = 1'b0;
                    if (!discard_q && !flush_i && !ptw_resp_fault_i) begin
                        pte_d   = ptw_resp_pte_i;
                        state_d = REFILL;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (flush_i) begin
                    discard_d = 1'b1;
                end
            end
            REFILL: begin
                valid_d = valid_q | victim_oh;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            valid_d = '0;
        end
    end

    always_comb begin
        lookup_ready_o  = (state_q == IDLE);
        rd_en_o         = '0;
        hit_o           = 1'b0;
        if (lookup_ready_o && lookup_valid_i) begin
            rd_en_o = lowest_one(hit_qual);
            hit_o   = |hit_qual;
        end
        ptw_req_valid_o = (state_q == PTW_REQ);
        ptw_req_vpn_o   = ptw_req_valid_o ? vpn_q : '0;
        fault_o         = (state_q == PTW_WAIT) && ptw_resp_valid_i && ptw_resp_fault_i &&
                          !discard_q && !flush_i;
        wr_en_o         = in_refill ? victim_oh : '0;
        pte_wr_o        = in_refill ? pte_q : '0;
        tag_wr_vpn_o    = in_refill ? vpn_q : '0;
        refill_done_o   = in_refill;
        valid_o         = valid_q;
    end

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Self-checking bench for itlb_refill_ctrl: directed scenarios plus random
// transactions checked against a transaction-level model of valid bits and victim order.
module tb_itlb_refill_ctrl;
    import mms_pkg::*;

    logic             clk;
    logic             rst;
    logic             lookup_valid;
    logic [VPN_W-1:0] lookup_vpn;
    entry_vec_t       hit_vec;
    logic             lookup_ready;
    entry_vec_t       rd_en;
    logic             hit;
    logic             req_valid;
    logic             req_ready;
    logic [VPN_W-1:0] req_vpn;
    logic             resp_valid;
    pte_t             resp_pte;
    logic             resp_fault;
    entry_vec_t       wr_en;
    pte_t             pte_wr;
    logic [VPN_W-1:0] tag_vpn;
    entry_vec_t       valid;
    logic             refill_done;
    logic             fault;
    logic             flush;

    int         n_assert = 0;
    int         n_fail   = 0;
    entry_vec_t mval;
    int         rr;
    entry_vec_t last_wr;

    itlb_refill_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .lookup_valid_i   (lookup_valid),
        .lookup_vpn_i     (lookup_vpn),
        .hit_vec_i        (hit_vec),
        .lookup_ready_o   (lookup_ready),
        .rd_en_o          (rd_en),
        .hit_o            (hit),
        .ptw_req_valid_o  (req_valid),
        .ptw_req_ready_i  (req_ready),
        .ptw_req_vpn_o    (req_vpn),
        .ptw_resp_valid_i (resp_valid),
        .ptw_resp_pte_i   (resp_pte),
        .ptw_resp_fault_i (resp_fault),
        .wr_en_o          (wr_en),
        .pte_wr_o         (pte_wr),
        .tag_wr_vpn_o     (tag_vpn),
        .valid_o          (valid),
        .refill_done_o    (refill_done),
        .fault_o          (fault),
        .flush_i          (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic entry_vec_t first_set(input entry_vec_t v);
        for (int i = 0; i < ITLB_ENTRY_SIZE; i++) begin
            if (v[i]) return entry_vec_t'(1) << i;
        end
        return '0;
    endfunction

    function automatic entry_vec_t pick_victim(output bit used_ptr);
        used_ptr = 1'b1;
`ifdef ITLB_INVALID_FIRST_EN
        if (~mval != '0) begin
            used_ptr = 1'b0;
            return first_set(~mval);
        end
`endif
        return entry_vec_t'(1) << rr;
    endfunction

    task automatic apply_reset();
        rst = 1'b1; lookup_valid = 0; lookup_vpn = '0; hit_vec = '0; req_ready = 0;
        resp_valid = 0; resp_pte = '0; resp_fault = 0; flush = 0;
        tick(); tick();
        rst = 1'b0;
        mval = '0;
        rr = 0;
    endtask

    task automatic do_hit(input entry_vec_t vec);
        entry_vec_t q;
        lookup_valid = 1'b1;
        lookup_vpn   = VPN_W'($urandom);
        hit_vec      = vec;
        #1;
        q = vec & mval;
        check_output("hit_rd_en", rd_en, first_set(q));
        check_output("hit_o", hit, q != '0);
        tick();
        lookup_valid = 1'b0;
        hit_vec      = '0;
        #1;
        check_output("hit_no_ptw", req_valid, 0);
        check_output("hit_ready", lookup_ready, 1);
    endtask

    // flush_mode: 0 none, 1 first PTW_WAIT cycle, 2 during REFILL, 3 first PTW_REQ cycle
    task automatic do_miss(input logic [VPN_W-1:0] vpn, input pte_t pte, input int rdy_dly,
                           input int rsp_dly, input bit flt, input int flush_mode);
        bit         disc = 1'b0;
        bit         used;
        entry_vec_t vic;
        lookup_valid = 1'b1;
        lookup_vpn   = vpn;
        hit_vec      = entry_vec_t'($urandom) & ~mval;
        #1;
        check_output("miss_hit_o", hit, 0);
        check_output("miss_rd_en", rd_en, 0);
        check_output("miss_ready", lookup_ready, 1);
        tick();
        lookup_valid = 1'b0;
        hit_vec      = '0;
        for (int c = 0; c <= rdy_dly; c++) begin
            req_ready = (c == rdy_dly);
            flush     = (flush_mode == 3) && (c == 0);
            #1;
            check_output("req_valid", req_valid, 1);
            check_output("req_vpn", req_vpn, vpn);
            check_output("req_busy", lookup_ready, 0);
            tick();
            if (flush) begin
                flush = 1'b0;
                mval  = '0;
                if (c != rdy_dly) begin
                    req_ready = 1'b0;
                    #1;
                    check_output("drop_ready", lookup_ready, 1);
                    check_output("drop_no_req", req_valid, 0);
                    return;
                end
                disc = 1'b1;
            end
        end
        req_ready = 1'b0;
        flush     = 1'b0;
        for (int c = 0; c <= rsp_dly; c++) begin
            resp_valid = (c == rsp_dly);
            resp_pte   = pte;
            resp_fault = flt;
            flush      = (flush_mode == 1) && (c == 0);
            if (flush) disc = 1'b1;
            #1;
            check_output("wait_no_req", req_valid, 0);
            check_output("wait_no_wr", wr_en, 0);
            check_output("fault_o", fault, (c == rsp_dly) && flt && !disc);
            tick();
            if (flush) mval = '0;
            flush = 1'b0;
        end
        resp_valid = 1'b0;
        resp_fault = 1'b0;
        if (flt || disc) begin
            #1;
            check_output("noref_ready", lookup_ready, 1);
            check_output("noref_wr", wr_en, 0);
            check_output("noref_done", refill_done, 0);
            check_output("noref_valid", valid, mval);
            return;
        end
        vic   = pick_victim(used);
        flush = (flush_mode == 2);
        #1;
        last_wr = wr_en;
        check_output("refill_wr_en", wr_en, vic);
        check_output("refill_pte", pte_wr, pte);
        check_output("refill_tag", tag_vpn, vpn);
        check_output("refill_done", refill_done, 1);
        check_output("refill_busy", lookup_ready, 0);
        tick();
        mval = flush ? '0 : (mval | vic);
        if (used) rr = (rr + 1) % ITLB_ENTRY_SIZE;
        flush = 1'b0;
        #1;
        check_output("post_valid", valid, mval);
        check_output("post_ready", lookup_ready, 1);
        check_output("post_done", refill_done, 0);
    endtask

    initial begin
        apply_reset();
        #1;
        check_output("rst_ready", lookup_ready, 1);
        check_output("rst_valid", valid, 0);
        check_output("rst_req", req_valid, 0);
        check_output("rst_wr", wr_en, 0);
        check_output("rst_done", refill_done, 0);
        check_output("rst_fault", fault, 0);
        check_output("rst_pte", pte_wr, 0);

        do_miss(VPN_W'('h123), pte_t'('hABCD), 3, 0, 1'b0, 0);
        check_output("first_wr_en", last_wr, 31'h1);
        check_output("first_valid", valid, 31'h1);
        do_miss(VPN_W'($urandom), {$urandom, $urandom}, 0, 1, 1'b0, 0);
        do_miss(VPN_W'($urandom), {$urandom, $urandom}, 1, 2, 1'b0, 0);
        do_hit(31'h4);
        check_output("hit4_const", valid & 31'h4, 31'h4);
        for (int i = 0; i < 3; i++) do_miss(VPN_W'($urandom), {$urandom, $urandom}, 0, 0, 1'b0, 0);
        do_hit(31'h30);

        do_miss(VPN_W'($urandom), {$urandom, $urandom}, 1, 1, 1'b1, 0);
        do_miss(VPN_W'($urandom), {$urandom, $urandom}, 0, 2, 1'b0, 1);
        check_output("flush_wait_valid", valid, 0);
        do_miss(VPN_W'($urandom), {$urandom, $urandom}, 0, 0, 1'b0, 0);
        do_miss(VPN_W'($urandom), {$urandom, $urandom}, 2, 0, 1'b0, 2);
        check_output("flush_refill_valid", valid, 0);
        do_miss(VPN_W'($urandom), {$urandom, $urandom}, 2, 0, 1'b0, 3);
        do_miss(VPN_W'($urandom), {$urandom, $urandom}, 0, 1, 1'b0, 3);

        apply_reset();
        for (int i = 0; i < 32; i++) begin
            do_miss(VPN_W'($urandom), {$urandom, $urandom}, 0, 0, 1'b0, 0);
`ifndef ITLB_INVALID_FIRST_EN
            if (i == 30) check_output("wrap_31st", last_wr, 31'h4000_0000);
            if (i == 31) check_output("wrap_32nd", last_wr, 31'h1);
`endif
        end

        for (int i = 0; i < 40; i++) begin
            int sel;
            int fm;
            sel = $urandom_range(0, 9);
            if (sel < 3 && mval != '0) begin
                entry_vec_t v;
                v = entry_vec_t'($urandom) & mval;
                if (v == '0) v = mval;
                v = v | (entry_vec_t'($urandom) & ~mval);
                do_hit(v);
            end else begin
                fm = $urandom_range(0, 11);
                if (fm > 3) fm = 0;
                do_miss(VPN_W'($urandom), {$urandom, $urandom}, $urandom_range(0, 3),
                        $urandom_range(0, 3), ($urandom_range(0, 7) == 0), fm);
            end
        end

        resp_valid = 1'b1;
        resp_fault = 1'b1;
        resp_pte   = {$urandom, $urandom};
        #1;
        check_output("idle_resp_fault", fault, 0);
        check_output("idle_resp_wr", wr_en, 0);
        tick();
        resp_valid = 1'b0;
        resp_fault = 1'b0;
        #1;
        check_output("idle_resp_ready", lookup_ready, 1);
        check_output("idle_resp_valid", valid, mval);

        lookup_valid = 1'b1;
        lookup_vpn   = VPN_W'($urandom);
        hit_vec      = entry_vec_t'($urandom) & ~mval;
        tick();
        lookup_valid = 1'b0;
        req_ready    = 1'b1;
        tick();
        req_ready = 1'b0;
        rst       = 1'b1;
        tick();
        rst  = 1'b0;
        mval = '0;
        rr   = 0;
        resp_valid = 1'b1;
        resp_pte   = {$urandom, $urandom};
        #1;
        check_output("rstmid_ready", lookup_ready, 1);
        check_output("rstmid_wr", wr_en, 0);
        tick();
        resp_valid = 1'b0;
        #1;
        check_output("rstmid_wr2", wr_en, 0);
        check_output("rstmid_valid", valid, 0);
        check_output("rstmid_done", refill_done, 0);
        do_miss(VPN_W'($urandom), {$urandom, $urandom}, 0, 0, 1'b0, 0);
        check_output("rstmid_ptr", last_wr, 31'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/itlb_refill_ctrl.md
# itlb_refill_ctrl

Miss-handling and replacement controller for the ITLB entry array. It turns tag-compare hit vectors into one-hot read enables, issues a page-table-walk request on a miss, and writes the returned PTE into a victim entry with a one-hot write enable. It sits between the IF-stage translation lookup, the shared PTW, and `itlb_entryArray`.

## Interface
- `ITLB_ENTRY_SIZE`, package constant, default 31: number of entries.
- `VPN_W`, package constant, default 27: virtual page number width.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `lookup_valid_i` in 1: a translation lookup is present this cycle.
- `lookup_vpn_i` in `VPN_W`: VPN of the lookup.
- `hit_vec_i` in `ITLB_ENTRY_SIZE`: raw tag-match vector from the tag compare.
- `lookup_ready_o` out 1: controller is in IDLE and can accept a lookup.
- `rd_en_o` out `ITLB_ENTRY_SIZE`: one-hot (or zero) read enable to the entry array.
- `hit_o` out 1: the lookup hit a valid entry.
- `ptw_req_valid_o` out 1 / `ptw_req_ready_i` in 1 / `ptw_req_vpn_o` out `VPN_W`: PTW request handshake.
- `ptw_resp_valid_i` in 1 / `ptw_resp_pte_i` in `MXLEN` / `ptw_resp_fault_i` in 1: PTW response (always accepted).
- `wr_en_o` out `ITLB_ENTRY_SIZE`: one-hot write enable to the entry array.
- `pte_wr_o` out `MXLEN`: PTE write data.
- `tag_wr_vpn_o` out `VPN_W`: VPN to store in the victim's tag.
- `valid_o` out `ITLB_ENTRY_SIZE`: per-entry valid bits.
- `refill_done_o` out 1: one-cycle pulse when a refill commits.
- `fault_o` out 1: one-cycle pulse when the walk returns a fault.
- `flush_i` in 1: sfence.vma; invalidates all entries.

## Operation
- **States:** IDLE, PTW_REQ, PTW_WAIT, REFILL.
- **Hit qualification:** `hit_q = hit_vec_i & valid_o`.
- **`rd_en_o`:** the lowest-index set bit of `hit_q`, gated by `lookup_valid_i` and IDLE. This keeps the array's OR reduction correct when there are multiple hits.
- **`hit_o`:** `|hit_q` under the same gating.
- **IDLE:**
  - On a miss (`lookup_valid_i & ~hit_o`, no `flush_i`), latch `lookup_vpn_i` and go to PTW_REQ.
  - `lookup_ready_o` is 1 only in IDLE.
- **PTW_REQ:**
  - `ptw_req_valid_o` = 1 and `ptw_req_vpn_o` = latched VPN, both held stable until `ptw_req_ready_i`.
  - On handshake, go to PTW_WAIT.
- **PTW_WAIT:**
  - On `ptw_resp_valid_i` with fault: pulse `fault_o`, no write, go to IDLE.
  - On `ptw_resp_valid_i` without fault: register the PTE and go to REFILL.
- **REFILL (one cycle):**
  - `wr_en_o` is one-hot at the victim; `pte_wr_o` and `tag_wr_vpn_o` are valid.
  - Set the victim's valid bit, pulse `refill_done_o`, advance the victim pointer, go to IDLE.
- **Victim pointer:** round-robin counter over 0..`ITLB_ENTRY_SIZE`-1. Increments only on a committed refill and wraps from N-1 to 0.
- **Flush:**
  - In IDLE or REFILL: `valid_o` becomes 0 the next cycle. A flush in the same cycle as REFILL still drives `wr_en_o`, but the valid bit ends up 0; flush wins.
  - In PTW_REQ before the handshake: drop the request and go to IDLE. If the handshake occurs in the same cycle, treat it as the PTW_WAIT case.
  - In PTW_WAIT: set `discard`. The response is consumed with no write, no `refill_done_o`, and no `fault_o`; go to IDLE.
- **Reset:** state IDLE, `valid_o` = 0, victim pointer = 0, `discard` = 0. All outputs are 0 except `lookup_ready_o` = 1.

## Timing
- **Hit:** `rd_en_o` is combinational, in the same cycle as the lookup. PTE data comes from the array in that cycle.
- **Miss:** `ptw_req_valid_o` rises 1 cycle after the miss cycle.
- **Refill:** `wr_en_o` asserts 1 cycle after `ptw_resp_valid_i`. `lookup_ready_o` returns the cycle after REFILL.
- **Minimum miss-to-ready:** 4 cycles with zero PTW latency.
- **Response timing:** `ptw_resp_valid_i` is ignored outside PTW_WAIT.
- **Write enables:** `wr_en_o` is never non-zero outside REFILL.
- **Reset mid-operation:** returns to IDLE next cycle. An outstanding PTW response arriving later is ignored.

## Configuration
- **`ITLB_INVALID_FIRST_EN` defined:** the victim is the lowest-index invalid entry when any exists. Otherwise the round-robin pointer is used. The pointer advances only when the pointer was used.
- **Undefined:** the victim is always the round-robin pointer.

## Structure
- **`mms_pkg`:** `ITLB_ENTRY_SIZE`, `VPN_W`, the `itlb_ctrl_state_e` enum, and the `pte_t` reuse.
- **Sub-module `itlb_victim_sel`:** the round-robin pointer plus the optional invalid-first priority encoder, producing a one-hot victim. Lowest-index priority encoding is a package function shared with the hit path.

## Test plan
- **Reset, then a hit:** lookup with `hit_vec_i` = 0x4, entry 2 valid -> same cycle `rd_en_o` = 0x4, `hit_o` = 1, no PTW request.
- **Miss, walk, refill:**
  - Lookup VPN 0x123 misses after reset -> PTW request with VPN 0x123 held through 3 not-ready cycles.
  - Response PTE 0xABCD -> `wr_en_o` = 0x1, `pte_wr_o` = 0xABCD, `valid_o` = 0x1, `refill_done_o` = 1.
- **Round-robin wrap (macro off):** 32 sequential refills -> the 32nd writes entry 0 again (`wr_en_o` = 0x1), and the 31st writes bit 30.
- **Faulting walk:** `ptw_resp_fault_i` = 1 -> `fault_o` pulse, `wr_en_o` stays 0, `valid_o` unchanged, pointer unchanged.
- **Flush during PTW_WAIT:** `flush_i` in PTW_WAIT, then response -> no write, no `refill_done_o`, `valid_o` = 0, back to IDLE.
- **Multi-hit, then flush with refill:**
  - `hit_vec_i` = 0x30 with both entries valid -> `rd_en_o` = 0x10.
  - `flush_i` coincident with REFILL -> `valid_o` = 0 the next cycle.
